// File: rtl/vme_slave_responder_pkg.sv
// Shared types and constants for the VME slave responder.
// FSM encoding, lane positions and default decode window.
package vme_slave_responder_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_WAIT    = 3'd2,
        S_ACK     = 3'd3,
        S_ERR     = 3'd4,
        S_RELEASE = 3'd5
    } state_e;

    localparam int LANE0 = 0;
    localparam int LANE1 = 1;

    localparam logic [31:0] DEF_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_MASK = 32'hFFFF_FFC0;

    // Expand the two lane strobes into a 32-bit byte-lane mask.
    function automatic logic [31:0] lane_mask(input logic [1:0] lanes);
        return {{16{lanes[LANE1]}}, {16{lanes[LANE0]}}};
    endfunction

endpackage

// File: rtl/vme_slave_responder_sync.sv
// Two-flop synchroniser for active-low bus strobes.
// Resets to all ones so strobes read as inactive.
module vme_slave_responder_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage resampling of the asynchronous strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vme_slave_responder.sv
// VME data-transfer responder: decode, register window,
// DTACK on mapped access, BERR on unmapped or misaligned access.
module vme_slave_responder
    import vme_slave_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE,
    parameter logic [31:0] ADDR_MASK   = DEF_MASK,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        as_n,
    input  logic        ds0_n,
    input  logic        ds1_n,
    input  logic        write_n,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_oe,
    output logic        dtack_n,
    output logic        berr_n,
    output logic [15:0] xfer_count
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic as_s, ds0_s, ds1_s;
    logic strb, rel, hit;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         lanes_q, lanes_d;
    logic               wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        regs_q [NUM_REGS];
    logic [31:0]        regs_d [NUM_REGS];
    logic [31:0]        data_out_q, data_out_d;
    logic               data_oe_q, data_oe_d;
    logic               dtack_n_q, dtack_n_d;
    logic               berr_n_q, berr_n_d;
    logic [15:0]        xfer_count_q, xfer_count_d;

    vme_slave_responder_sync #(.WIDTH(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({ds1_n, ds0_n, as_n}),
        .q   ({ds1_s, ds0_s, as_s})
    );

    assign strb = !as_s && (!ds0_s || !ds1_s);
    assign rel  = as_s && ds0_s && ds1_s;
    assign hit  = (address & ADDR_MASK) == BASE_ADDR;

    // Next-state, register-file update and bus output decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        lanes_d      = lanes_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        regs_d       = regs_q;
        data_out_d   = data_out_q;
        data_oe_d    = data_oe_q;
        dtack_n_d    = dtack_n_q;
        berr_n_d     = berr_n_q;
        xfer_count_d = xfer_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (strb) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (hit && address[1:0] == 2'b00) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_CYCLES[7:0];
                    idx_d   = address[2+:IDX_W];
                    lanes_d = {!ds1_s, !ds0_s};
                    wr_d    = !write_n;
                    wdata_d = data_in;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_WAIT: begin
                if (as_s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d      = S_ACK;
                    dtack_n_d    = 1'b0;
                    xfer_count_d = xfer_count_q + 16'd1;
                    if (wr_q) begin
                        if (lanes_q[LANE0]) regs_d[idx_q][15:0]  = wdata_q[15:0];
                        if (lanes_q[LANE1]) regs_d[idx_q][31:16] = wdata_q[31:16];
                    end else begin
                        data_out_d = regs_q[idx_q] & lane_mask(lanes_q);
                        data_oe_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACK: begin
                if (rel) begin
                    state_d    = S_RELEASE;
                    dtack_n_d  = 1'b1;
                    data_oe_d  = 1'b0;
                    data_out_d = '0;
                end
            end
            S_ERR: begin
                if (rel) begin
                    state_d  = S_RELEASE;
                    berr_n_d = 1'b1;
                end else begin
                    berr_n_d = 1'b0;
                end
            end
            S_RELEASE: begin
                state_d    = S_IDLE;
                dtack_n_d  = 1'b1;
                berr_n_d   = 1'b1;
                data_oe_d  = 1'b0;
                data_out_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, register file and registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            lanes_q      <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            regs_q       <= '{default: '0};
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            dtack_n_q    <= 1'b1;
            berr_n_q     <= 1'b1;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lanes_q      <= lanes_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            regs_q       <= regs_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            dtack_n_q    <= dtack_n_d;
            berr_n_q     <= berr_n_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign dtack_n    = dtack_n_q;
    assign berr_n     = berr_n_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_vme_slave_responder.sv
// Scoreboard bench for vme_slave_responder.
// Two instances: default window (0x1000, 2 waits) and 0x3000 with 8 waits.
module tb_vme_slave_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic        as_n = 1'b1;
    logic        ds0_n = 1'b1;
    logic        ds1_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] data_in = '0;

    logic [31:0] dout0, dout1;
    logic        oe0, oe1, dtack0, dtack1, berr0, berr1;
    logic [15:0] cnt0, cnt1;

    int sel = 0;
    logic [31:0] dout_s;
    logic        oe_s, dtack_s, berr_s;
    logic [15:0] cnt_s;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        logic [15:0] cnt;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    logic [31:0] m_regs [2][16];
    logic [15:0] m_cnt [2];
    logic [31:0] m_base [2];
    int          m_wait [2];

    always #5 clk = ~clk;

    vme_slave_responder u_dut0 (
        .clk(clk), .rst(rst), .address(address), .as_n(as_n),
        .ds0_n(ds0_n), .ds1_n(ds1_n), .write_n(write_n),
        .data_in(data_in), .data_out(dout0), .data_oe(oe0),
        .dtack_n(dtack0), .berr_n(berr0), .xfer_count(cnt0)
    );

    vme_slave_responder #(
        .BASE_ADDR(32'h0000_3000),
        .WAIT_CYCLES(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .address(address), .as_n(as_n),
        .ds0_n(ds0_n), .ds1_n(ds1_n), .write_n(write_n),
        .data_in(data_in), .data_out(dout1), .data_oe(oe1),
        .dtack_n(dtack1), .berr_n(berr1), .xfer_count(cnt1)
    );

    assign dout_s  = (sel == 1) ? dout1 : dout0;
    assign oe_s    = (sel == 1) ? oe1 : oe0;
    assign dtack_s = (sel == 1) ? dtack1 : dtack0;
    assign berr_s  = (sel == 1) ? berr1 : berr0;
    assign cnt_s   = (sel == 1) ? cnt1 : cnt0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = '0;
            for (int r = 0; r < 16; r++) m_regs[d][r] = '0;
        end
    endtask

    task automatic access(input int s, input logic [31:0] a, input bit we,
                          input bit l0, input bit l1, input logic [31:0] wd);
        exp_t e;
        bit   mapped;
        int   idx;
        int   n;
        bit   got;
        logic [31:0] msk;
        mapped = ((a & 32'hFFFF_FFC0) == m_base[s]) && (a[1:0] == 2'b00);
        idx = int'(a[5:2]);
        msk = {{16{l1}}, {16{l0}}};
        e.err = !mapped;
        e.rd = !we;
        e.data = '0;
        e.lat = mapped ? m_wait[s] + 5 : 5;
        if (mapped) begin
            m_cnt[s] = m_cnt[s] + 16'd1;
            if (we) m_regs[s][idx] = (m_regs[s][idx] & ~msk) | (wd & msk);
            else e.data = m_regs[s][idx] & msk;
        end
        e.cnt = m_cnt[s];
        sbq.push_back(e);

        @(negedge clk);
        sel = s;
        address = a;
        write_n = !we;
        data_in = wd;
        as_n = 1'b0;
        ds0_n = !l0;
        ds1_n = !l1;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!dtack_s || !berr_s) got = 1;
        end
        e = sbq.pop_front();
        check("resp_seen", 64'(got), 64'd1);
        check("latency", 64'(n), 64'(e.lat));
        check("ack_err", {62'd0, !dtack_s, !berr_s},
              {62'd0, !e.err, e.err});
        check("data_oe", 64'(oe_s), 64'(e.rd && !e.err));
        check("data_out", 64'(dout_s), 64'((e.rd && !e.err) ? e.data : 32'd0));
        check("xfer_count", 64'(cnt_s), 64'(e.cnt));

        @(negedge clk);
        as_n = 1'b1;
        ds0_n = 1'b1;
        ds1_n = 1'b1;
        n = 0;
        while ((!dtack_s || !berr_s || oe_s) && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("release", {61'd0, dtack_s, berr_s, oe_s}, 64'b110);
        check("release_dout", 64'(dout_s), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;
        bit seen;
        m_base[0] = 32'h0000_1000;
        m_base[1] = 32'h0000_3000;
        m_wait[0] = 2;
        m_wait[1] = 8;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_dtack", 64'(dtack0), 64'd1);
        check("rst_berr", 64'(berr0), 64'd1);
        check("rst_oe", 64'(oe0), 64'd0);
        check("rst_dout", 64'(dout0), 64'd0);
        check("rst_cnt", 64'(cnt0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        access(0, 32'h0000_1004, 1, 1, 1, 32'hDEAD_BEEF);
        access(0, 32'h0000_1004, 0, 1, 1, 32'h0);
        access(0, 32'h0000_1008, 1, 0, 1, 32'h1234_5678);
        access(0, 32'h0000_1008, 0, 1, 1, 32'h0);
        access(0, 32'h0000_1008, 1, 1, 0, 32'h1234_5678);
        access(0, 32'h0000_1008, 0, 1, 0, 32'h0);
        access(0, 32'h0000_1004, 0, 0, 1, 32'h0);
        access(0, 32'h0000_2000, 1, 1, 1, 32'hFFFF_FFFF);
        access(0, 32'h0000_1002, 1, 1, 1, 32'hFFFF_FFFF);
        access(0, 32'h0000_103C, 1, 1, 1, 32'hCAFE_F00D);
        access(0, 32'h0000_1004, 0, 1, 1, 32'h0);
        access(0, 32'h0000_103C, 0, 1, 1, 32'h0);

        // Abort in the wait phase on the slow instance.
        @(negedge clk);
        sel = 1;
        address = 32'h0000_3004;
        write_n = 1'b0;
        data_in = 32'hA5A5_A5A5;
        as_n = 1'b0;
        ds0_n = 1'b0;
        ds1_n = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (!dtack1) seen = 1;
        end
        @(negedge clk);
        as_n = 1'b1;
        ds0_n = 1'b1;
        ds1_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!dtack1) seen = 1;
        end
        check("abort_no_dtack", 64'(seen), 64'd0);
        check("abort_cnt", 64'(cnt1), 64'(m_cnt[1]));
        access(1, 32'h0000_3004, 0, 1, 1, 32'h0);
        access(1, 32'h0000_3004, 1, 1, 1, 32'h0BAD_CAFE);
        access(1, 32'h0000_3004, 0, 1, 1, 32'h0);

        // Counter wrap from all ones.
        @(negedge clk);
        force u_dut0.xfer_count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut0.xfer_count_q;
        m_cnt[0] = 16'hFFFF;
        access(0, 32'h0000_1010, 1, 1, 1, 32'h0101_0101);

        // Reset while acknowledging.
        @(negedge clk);
        sel = 0;
        address = 32'h0000_1014;
        write_n = 1'b1;
        as_n = 1'b0;
        ds0_n = 1'b0;
        ds1_n = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!dtack0) seen = 1;
        end
        check("mid_ack_seen", 64'(seen), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_dtack", 64'(dtack0), 64'd1);
        check("mid_rst_oe", 64'(oe0), 64'd0);
        check("mid_rst_cnt", 64'(cnt0), 64'd0);
        @(negedge clk);
        as_n = 1'b1;
        ds0_n = 1'b1;
        ds1_n = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        access(0, 32'h0000_1004, 0, 1, 1, 32'h0);
        access(0, 32'h0000_1010, 0, 1, 1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
